px_word_packer: RTL and testbench
=================================

# px_word_packer

Packs the filtered pixel stream leaving the low-pass filter top (`px_out_*`) into NPX-pixel words for the frame-buffer write path. Sits directly downstream of the filter and accepts its per-pixel stream, including the last-column and last-row flags. Emits one word per NPX pixels with lane-keep bits and row/frame markers. Asserts `done` once the final word of the frame has been accepted.

## Interface

- `PB`, 8, pixel width in bits
- `NPX`, 4, pixels per output word (power of two, 2..8)
- `YB`, 10, row counter width
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `px_in_ready`  out  1  pixel accepted on edge where ready & valid
- `px_in_valid`  in  1  pixel valid
- `px_in_last_x`  in  1  pixel is last in its row
- `px_in_last_y`  in  1  pixel is in last row
- `px_in_data`  in  PB  filtered pixel
- `word_out_ready`  in  1  consumer accepts word
- `word_out_valid`  out  1  word valid
- `word_out_data`  out  NPX*PB  lane i in bits [i*PB +: PB], lane 0 = earliest pixel
- `word_out_keep`  out  NPX  bit i set = lane i holds a real pixel
- `word_out_eol`  out  1  word contains a row's last pixel
- `word_out_eof`  out  1  final word of frame
- `rows_done`  out  YB  count of rows fully packed (eol words accepted)
- `done`  out  1  sticky: eof word accepted

## Operation

- Datapath: assembly register (NPX lanes + keep) with lane index `lane` (log2 NPX bits); one-entry output register.
- `px_in_ready = ~word_out_valid | word_out_ready`, forced 0 in state DONE.
- On each input handshake: write the pixel into lane `lane` and set its keep bit. The word completes if any of the following holds:
  - `lane == NPX-1`
  - row-pad flush condition (see Configuration)
  - `px_in_last_x & px_in_last_y`
- On completion: the assembly (including the current pixel) moves to the output register in the same edge. The assembly keep clears and `lane` becomes 0. Otherwise `lane` increments.
- `word_out_eol`: set if the word holds any pixel flagged `last_x`. `word_out_eof`: set if the word holds the `last_x & last_y` pixel.
- Unfilled lanes: data 0, keep 0.
- Output register: loaded on completion; `word_out_valid` clears on handshake unless reloaded in the same edge.
- `rows_done` increments on each accepted word with `eol=1`; it wraps modulo 2^YB.
- States:
  - RUN: reset state.
  - RUN→DONE on handshake of the eof word.
  - DONE: `done=1`, `px_in_ready=0`, holds until `rst_n` low.
- Input pixels presented while in DONE are not accepted; there is no error path.
- Reset mid-frame: all state discarded immediately, including partial words; no flush.

## Timing

- Reset values: `px_in_ready` 1 (RUN, output empty), `word_out_valid` 0, `word_out_data` 0, `word_out_keep` 0, `word_out_eol` 0, `word_out_eof` 0, `rows_done` 0, `done` 0.
- Latency: `word_out_valid` rises on the edge after the completing pixel's handshake (1 cycle).
- Throughput: one pixel per cycle while `word_out_ready=1`. The consumer sees at most one word per cycle.
- Backpressure: with `word_out_valid=1 & word_out_ready=0`, `px_in_ready` is low combinationally in the same cycle.
- Output signals are held stable while valid & !ready.
- Simultaneous events: output handshake and a new completion on the same edge → the output register reloads and `word_out_valid` stays 1.
- `done` rises the edge after the eof handshake. `px_in_ready` falls on that same edge.

## Configuration

- `PX_PACKER_ROW_PAD_EN` defined:
  - A pixel with `px_in_last_x=1` always completes the word.
  - Every row starts at lane 0, and partial row-end words carry keep < all-ones.
- Not defined:
  - Pixels pack continuously across row boundaries; only a full word or the frame-final pixel completes a word.
  - `eol` marks any word containing a row-last pixel, and `rows_done` counts those words.

## Test plan

- PAD_EN, NPX=4, 3×2 image (pixels 1..6), ready=1 → 2 words: data 0x00030201 keep 4'b0111 eol=1 eof=0; then 0x00060504 keep 4'b0111 eol=1 eof=1; `rows_done`=2; `done` high 1 cycle after the second handshake.
- No PAD_EN, same stimulus → words 0x04030201 keep 4'b1111 eol=1; then 0x00000605 keep 4'b0011 eol=1 eof=1; `rows_done`=2.
- 8×1 image, ready=1, valid=1 continuous → words on cycles 5 and 9 after the first handshake, keep 4'b1111 each, `px_in_ready` never low.
- `word_out_ready` held 0 for 5 cycles with a word pending → `px_in_ready`=0 throughout; data/keep/eol stable; on release, the pending word transfers and input resumes next cycle with no pixel lost or duplicated.
- 1×1 image (single pixel 0xAB) → one word 0x000000AB keep 4'b0001 eol=1 eof=1; then DONE with `px_in_ready`=0.
- `rst_n` pulsed low mid-word (after 2 pixels of 4×4) → all outputs go to reset values asynchronously. A fresh frame after release produces its first word with lane 0 = first new pixel.

Source files
------------

// File: rtl/px_word_packer.sv
// Packs the filtered pixel stream into NPX-lane words with keep, row and frame markers.
// Optional build macro PX_PACKER_ROW_PAD_EN: every row-last pixel closes its word.
module px_word_packer #(
    parameter int unsigned PB  = 8,
    parameter int unsigned NPX = 4,
    parameter int unsigned YB  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              px_in_ready,
    input  logic              px_in_valid,
    input  logic              px_in_last_x,
    input  logic              px_in_last_y,
    input  logic [PB-1:0]     px_in_data,
    input  logic              word_out_ready,
    output logic              word_out_valid,
    output logic [NPX*PB-1:0] word_out_data,
    output logic [NPX-1:0]    word_out_keep,
    output logic              word_out_eol,
    output logic              word_out_eof,
    output logic [YB-1:0]     rows_done,
    output logic              done
);

    localparam int unsigned   LW       = $clog2(NPX);
    localparam logic [LW-1:0] LastLane = LW'(NPX - 1);

    typedef enum logic {StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic [LW-1:0]       lane_q, lane_d;
    logic [NPX*PB-1:0]   asm_data_q, asm_data_d;
    logic [NPX-1:0]      asm_keep_q, asm_keep_d;
    logic                asm_eol_q, asm_eol_d;
    logic                out_valid_q, out_valid_d;
    logic [NPX*PB-1:0]   out_data_q, out_data_d;
    logic [NPX-1:0]      out_keep_q, out_keep_d;
    logic                out_eol_q, out_eol_d;
    logic                out_eof_q, out_eof_d;
    logic [YB-1:0]       rows_q, rows_d;

    logic                in_hs, out_hs, row_flush, word_end, complete;
    logic [NPX*PB-1:0]   data_merged;
    logic [NPX-1:0]      keep_merged;

    assign in_hs  = px_in_valid & px_in_ready;
    assign out_hs = out_valid_q & word_out_ready;

`ifdef PX_PACKER_ROW_PAD_EN
    assign row_flush = px_in_last_x;
`else
    assign row_flush = 1'b0;
`endif

    assign word_end = (lane_q == LastLane) | row_flush | (px_in_last_x & px_in_last_y);
    assign complete = in_hs & word_end;

    // Assembly contents including the pixel currently on the input.
    always_comb begin
        data_merged = asm_data_q;
        keep_merged = asm_keep_q;
        for (int i = 0; i < NPX; i++) begin
            if (lane_q == LW'(i)) begin
                data_merged[i*PB +: PB] = px_in_data;
                keep_merged[i]          = 1'b1;
            end
        end
    end

    always_comb begin
        asm_data_d  = asm_data_q;
        asm_keep_d  = asm_keep_q;
        asm_eol_d   = asm_eol_q;
        lane_d      = lane_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_eol_d   = out_eol_q;
        out_eof_d   = out_eof_q;
        rows_d      = rows_q;
        state_d     = state_q;

        if (in_hs) begin
            if (complete) begin
                asm_data_d = '0;
                asm_keep_d = '0;
                asm_eol_d  = 1'b0;
                lane_d     = '0;
            end else begin
                asm_data_d = data_merged;
                asm_keep_d = keep_merged;
                asm_eol_d  = asm_eol_q | px_in_last_x;
                lane_d     = lane_q + LW'(1);
            end
        end

        // A reload on the same edge as a handshake keeps valid high.
        if (complete) begin
            out_valid_d = 1'b1;
            out_data_d  = data_merged;
            out_keep_d  = keep_merged;
            out_eol_d   = asm_eol_q | px_in_last_x;
            out_eof_d   = px_in_last_x & px_in_last_y;
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end

        if (out_hs && out_eol_q) begin
            rows_d = rows_q + YB'(1);
        end

        if (state_q == StRun && out_hs && out_eof_q) begin
            state_d = StDone;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            lane_q      <= '0;
            asm_data_q  <= '0;
            asm_keep_q  <= '0;
            asm_eol_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            rows_q      <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            asm_data_q  <= asm_data_d;
            asm_keep_q  <= asm_keep_d;
            asm_eol_q   <= asm_eol_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_eol_q   <= out_eol_d;
            out_eof_q   <= out_eof_d;
            rows_q      <= rows_d;
        end
    end

    assign px_in_ready    = (state_q == StRun) & (~out_valid_q | word_out_ready);
    assign word_out_valid = out_valid_q;
    assign word_out_data  = out_data_q;
    assign word_out_keep  = out_keep_q;
    assign word_out_eol   = out_eol_q;
    assign word_out_eof   = out_eof_q;
    assign rows_done      = rows_q;
    assign done           = (state_q == StDone);

endmodule

// File: tb/tb_px_word_packer.sv
// Randomized bench for px_word_packer: frames are chunked into expected words by a queue
// model (per-row segments when PX_PACKER_ROW_PAD_EN is defined, whole frame otherwise).
`timescale 1ns/1ps
module tb_px_word_packer;

    localparam int unsigned PB  = 8;
    localparam int unsigned NPX = 4;
    localparam int unsigned YB  = 10;
    localparam int unsigned WW  = NPX * PB;

`ifdef PX_PACKER_ROW_PAD_EN
    localparam bit Pad = 1'b1;
`else
    localparam bit Pad = 1'b0;
`endif

    typedef struct packed {
        logic [WW-1:0]  data;
        logic [NPX-1:0] keep;
        logic           eol;
        logic           eof;
    } word_t;

    logic              clk;
    logic              rst_n;
    logic              px_in_ready;
    logic              px_in_valid;
    logic              px_in_last_x;
    logic              px_in_last_y;
    logic [PB-1:0]     px_in_data;
    logic              word_out_ready;
    logic              word_out_valid;
    logic [WW-1:0]     word_out_data;
    logic [NPX-1:0]    word_out_keep;
    logic              word_out_eol;
    logic              word_out_eof;
    logic [YB-1:0]     rows_done;
    logic              done;

    logic [PB-1:0] pix_q[$];
    word_t         exp_q[$];
    word_t         got_q[$];
    int            n_checks;
    int            n_fails;

    px_word_packer #(
        .PB (PB),
        .NPX(NPX),
        .YB (YB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .px_in_ready   (px_in_ready),
        .px_in_valid   (px_in_valid),
        .px_in_last_x  (px_in_last_x),
        .px_in_last_y  (px_in_last_y),
        .px_in_data    (px_in_data),
        .word_out_ready(word_out_ready),
        .word_out_valid(word_out_valid),
        .word_out_data (word_out_data),
        .word_out_keep (word_out_keep),
        .word_out_eol  (word_out_eol),
        .word_out_eof  (word_out_eof),
        .rows_done     (rows_done),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected words: split the frame into segments, then each segment into NPX-pixel chunks.
    task automatic build_frame(input int w, input int h, input bit seq, input int base,
                               output int rows);
        int    n;
        int    seg;
        word_t wd;
        n    = w * h;
        rows = 0;
        pix_q.delete();
        exp_q.delete();
        for (int i = 0; i < n; i++)
            pix_q.push_back(seq ? PB'(base + i) : PB'($urandom_range(255)));
        seg = Pad ? w : n;
        for (int s = 0; s < n; s += seg) begin
            for (int g = s; g < s + seg; g += NPX) begin
                wd = '0;
                for (int k = 0; k < NPX && g + k < s + seg; k++) begin
                    wd.data[k*PB +: PB] = pix_q[g+k];
                    wd.keep[k] = 1'b1;
                    if ((g + k) % w == w - 1) wd.eol = 1'b1;
                    if (g + k == n - 1)       wd.eof = 1'b1;
                end
                exp_q.push_back(wd);
                if (wd.eol) rows++;
            end
        end
    endtask

    task automatic apply_reset();
        px_in_valid    = 1'b0;
        px_in_last_x   = 1'b0;
        px_in_last_y   = 1'b0;
        px_in_data     = '0;
        word_out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_in_ready", px_in_ready, 1);
        check_eq("rst_out", {word_out_valid, word_out_data, word_out_keep, word_out_eol,
                             word_out_eof}, 0);
        check_eq("rst_rows", rows_done, 0);
        check_eq("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Cycle numbers returned are relative to the first input handshake (= cycle 1).
    task automatic run_frame(input int w, input int h, input int vprob, input int rprob,
                             input int stall, input bit seq, input int base,
                             output int ready_lows, output int first_wc, output int eof_wc);
        int    rows, idx, n, cyc, c0, done_cyc, hold;
        word_t prev, cur, e;
        bit    prev_stall;
        build_frame(w, h, seq, base, rows);
        n = w * h; idx = 0; cyc = 0; c0 = -1; done_cyc = -1; hold = stall;
        first_wc = -1; eof_wc = -1; ready_lows = 0; prev_stall = 1'b0; prev = '0;
        got_q.delete();
        while (cyc < 3000) begin
            cyc++;
            px_in_valid    = (idx < n) && ($urandom_range(99) < vprob);
            px_in_data     = (idx < n) ? pix_q[idx] : '0;
            px_in_last_x   = (idx < n) && (idx % w == w - 1);
            px_in_last_y   = (idx < n) && (idx / w == h - 1);
            word_out_ready = (hold > 0) ? 1'b0 : ($urandom_range(99) < rprob);
            @(negedge clk);
            cur.data = word_out_data;
            cur.keep = word_out_keep;
            cur.eol  = word_out_eol;
            cur.eof  = word_out_eof;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (prev_stall) check_eq("hold_stable", {word_out_valid, cur}, {1'b1, prev});
            if (word_out_valid && !word_out_ready) check_eq("bp_in_ready", px_in_ready, 0);
            if (!px_in_ready) ready_lows++;
            if (word_out_valid && first_wc < 0 && c0 >= 0) first_wc = cyc - c0 + 1;
            if (px_in_valid && px_in_ready) begin
                if (c0 < 0) c0 = cyc;
                idx++;
            end
            if (word_out_valid && word_out_ready) begin
                got_q.push_back(cur);
                check_eq("word_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("word_data", cur.data, e.data);
                    check_eq("word_keep", cur.keep, e.keep);
                    check_eq("word_flags", {cur.eol, cur.eof}, {e.eol, e.eof});
                end
                if (cur.eof) eof_wc = cyc - c0 + 1;
            end
            if (word_out_valid && hold > 0) hold--;
            prev_stall = word_out_valid && !word_out_ready;
            prev = cur;
            @(posedge clk);
            #1;
        end
        check_eq("done_reached", done, 1);
        check_eq("done_latency", done_cyc - c0 + 1, eof_wc + 1);
        check_eq("words_left", exp_q.size(), 0);
        check_eq("pixels_sent", idx, n);
        check_eq("rows_done", rows_done, rows % (1 << YB));
        // DONE must refuse further pixels and produce nothing.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            px_in_valid    = 1'b1;
            px_in_data     = 8'h5A;
            word_out_ready = 1'b1;
            @(negedge clk);
            check_eq("done_hold", {done, px_in_ready, word_out_valid}, 3'b100);
        end
        px_in_valid = 1'b0;
    endtask

    initial begin
        int rl, fw, ew;
        n_checks = 0;
        n_fails  = 0;
        rst_n          = 1'b0;
        px_in_valid    = 1'b0;
        px_in_last_x   = 1'b0;
        px_in_last_y   = 1'b0;
        px_in_data     = '0;
        word_out_ready = 1'b0;

        // 3x2 image, pixels 1..6
        apply_reset();
        run_frame(3, 2, 100, 100, 0, 1'b1, 1, rl, fw, ew);
        check_eq("t1_n_words", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check_eq("t1_w0", got_q[0], Pad ? {32'h00030201, 4'b0111, 2'b10}
                                            : {32'h04030201, 4'b1111, 2'b10});
            check_eq("t1_w1", got_q[1], Pad ? {32'h00060504, 4'b0111, 2'b11}
                                            : {32'h00000605, 4'b0011, 2'b11});
        end

        // 8x1 continuous stream at full rate
        apply_reset();
        run_frame(8, 1, 100, 100, 0, 1'b0, 0, rl, fw, ew);
        check_eq("t2_ready_lows", rl, 0);
        check_eq("t2_first_word_cycle", fw, 5);
        check_eq("t2_eof_cycle", ew, 9);

        // Consumer stall of 5 cycles on the first word
        apply_reset();
        run_frame(8, 2, 100, 100, 5, 1'b0, 0, rl, fw, ew);

        // Single pixel frame
        apply_reset();
        run_frame(1, 1, 100, 100, 0, 1'b1, 8'hAB, rl, fw, ew);
        check_eq("t4_n_words", got_q.size(), 1);
        if (got_q.size() == 1) check_eq("t4_w0", got_q[0], {32'h000000AB, 4'b0001, 2'b11});

        // Reset after two pixels of a 4x4 frame, then a fresh frame
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            px_in_valid    = 1'b1;
            px_in_data     = PB'(8'h55 + i);
            px_in_last_x   = 1'b0;
            px_in_last_y   = 1'b0;
            word_out_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        apply_reset();
        run_frame(4, 4, 80, 80, 0, 1'b0, 0, rl, fw, ew);

        // Random frames with random valid/ready duty
        for (int f = 0; f < 12; f++) begin
            apply_reset();
            run_frame(int'($urandom_range(1, 9)), int'($urandom_range(1, 4)),
                      int'($urandom_range(40, 100)), int'($urandom_range(30, 100)),
                      int'($urandom_range(0, 3)), 1'b0, 0, rl, fw, ew);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
